// File: rtl/apb_cmd_sequencer.sv
// Command-list sequencer for APB_master: fetches commands from a single-port memory,
// issues APB reads/writes, and writes read data back to a result area.
module apb_cmd_sequencer #(
    parameter int SEL_WIDTH  = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESET,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_cmd_base,
    input  logic [ADDR_WIDTH-1:0] i_res_base,
    output logic                  o_m_en,
    output logic                  o_m_wr,
    output logic [ADDR_WIDTH-1:0] o_m_addr,
    output logic [DATA_WIDTH-1:0] o_m_data_w,
    input  logic [DATA_WIDTH-1:0] i_m_data_r,
    output logic                  o_apb_enable,
    output logic                  o_apb_wr,
    output logic [SEL_WIDTH-1:0]  o_apb_slave,
    output logic [ADDR_WIDTH-1:0] o_apb_addr,
    output logic [DATA_WIDTH-1:0] o_apb_wdata,
    input  logic                  i_apb_busy,
    input  logic                  i_apb_valid,
    input  logic [DATA_WIDTH-1:0] i_apb_rdata,
    input  logic                  i_PSLVERR,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_status,
    output logic [ADDR_WIDTH-1:0] o_cmd_cnt,
    output logic [ADDR_WIDTH-1:0] o_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_STORE, S_DONE
    } state_t;

    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

    state_t                state, state_nxt;
    logic                  phase;          // 0: memory read issued, 1: word captured
    logic [ADDR_WIDTH-1:0] cmd_ptr, res_ptr, addr_q;
    logic [1:0]            hdr_op;
    logic [SEL_WIDTH-1:0]  hdr_slave;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [TW-1:0]         timer;
    logic [1:0]            word_op;

    assign word_op = i_m_data_r[DATA_WIDTH-1 -: 2];
    assign o_busy  = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output is given a default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt    = state;
        o_m_en       = 1'b0;
        o_m_wr       = 1'b0;
        o_m_addr     = '0;
        o_m_data_w   = '0;
        o_apb_enable = 1'b0;
        o_done       = 1'b0;
        case (state)
            S_IDLE: if (i_start) state_nxt = S_HDR;
            S_HDR, S_ADDR, S_DATA: begin
                if (!phase) begin
                    o_m_en   = 1'b1;
                    o_m_addr = cmd_ptr;
                end else if (state == S_HDR) begin
                    state_nxt = (word_op == OP_END || word_op == OP_ILL) ? S_DONE : S_ADDR;
                end else if (state == S_ADDR) begin
                    state_nxt = (hdr_op == OP_WRITE) ? S_DATA : S_ISSUE;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: if (!i_apb_busy) begin
                o_apb_enable = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final allowed cycle beats the timeout.
                if (i_apb_valid)              state_nxt = (hdr_op == OP_READ) ? S_STORE : S_HDR;
                else if (timer == TIMER_LAST) state_nxt = S_DONE;
            end
            S_STORE: begin
                o_m_en     = 1'b1;
                o_m_wr     = 1'b1;
                o_m_addr   = res_ptr;
                o_m_data_w = rdata_q;
                state_nxt  = S_HDR;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            phase       <= 1'b0;
            cmd_ptr     <= '0;
            res_ptr     <= '0;
            addr_q      <= '0;
            hdr_op      <= OP_END;
            hdr_slave   <= '0;
            rdata_q     <= '0;
            timer       <= '0;
            o_apb_wr    <= 1'b0;
            o_apb_slave <= '0;
            o_apb_addr  <= '0;
            o_apb_wdata <= '0;
            o_status    <= 2'b00;
            o_cmd_cnt   <= '0;
            o_err_cnt   <= '0;
        end else begin
            phase <= (state == S_HDR || state == S_ADDR || state == S_DATA) ? ~phase : 1'b0;
            case (state)
                S_IDLE: if (i_start) begin
                    cmd_ptr   <= i_cmd_base;
                    res_ptr   <= i_res_base;
                    o_cmd_cnt <= '0;
                    o_err_cnt <= '0;
                    o_status  <= 2'b00;
                end
                S_HDR: if (phase) begin
                    cmd_ptr   <= cmd_ptr + ONE;
                    hdr_op    <= word_op;
                    hdr_slave <= i_m_data_r[SEL_WIDTH-1:0];
                    if (word_op == OP_ILL) o_status <= 2'b01;
                end
                S_ADDR: if (phase) begin
                    cmd_ptr <= cmd_ptr + ONE;
                    addr_q  <= i_m_data_r;
                    // Reads go straight to ISSUE, so the bus fields are loaded now.
                    if (hdr_op == OP_READ) begin
                        o_apb_wr    <= 1'b0;
                        o_apb_slave <= hdr_slave;
                        o_apb_addr  <= i_m_data_r;
                    end
                end
                S_DATA: if (phase) begin
                    cmd_ptr     <= cmd_ptr + ONE;
                    o_apb_wr    <= 1'b1;
                    o_apb_slave <= hdr_slave;
                    o_apb_addr  <= addr_q;
                    o_apb_wdata <= i_m_data_r;
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    if (i_apb_valid) begin
                        o_cmd_cnt <= o_cmd_cnt + ONE;
                        o_err_cnt <= o_err_cnt + ADDR_WIDTH'(i_PSLVERR);
                        rdata_q   <= i_apb_rdata;
                    end else begin
                        timer <= timer + TW'(1);
                        if (timer == TIMER_LAST) o_status <= 2'b10;
                    end
                end
                S_STORE: res_ptr <= res_ptr + ONE;
                default: ;
            endcase
        end
    end

endmodule
